// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
// lead_zero() is only referenced when LEADING_ZERO_BLANK_EN is defined.
package seg_pkg;

   localparam int DIGITS   = 4;
   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DIGITS*NIBBLE_W-1:0] data;
      logic [DIGITS-1:0]          mode;
      logic [DIGITS-1:0]          dp;
   } disp_t;

   // True when digit idx (>0) and every more significant nibble are zero.
   function automatic logic lead_zero(input logic [DIGITS*NIBBLE_W-1:0] data,
                                      input logic [1:0] idx);
      logic r;
      r = 1'b0;
      case (idx)
         2'd1:    r = (data[15:4] == 12'h000);
         2'd2:    r = (data[15:8] == 8'h00);
         2'd3:    r = (data[15:12] == 4'h0);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Slot counter for the digit scanner: counts 0..SLOT_CYCLES-1 while run is
// high, clears when run is low, and flags the BLANK/SHOW/slot boundaries.
module seg_refresh_timer #(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic blank_end,
   output logic slot_end,
   output logic slot_end_nx
);

   localparam int            CW    = $clog2(SLOT_CYCLES);
   localparam logic [CW-1:0] LAST  = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;

   // Next count: cleared when idle, wraps to zero at the end of a slot.
   always_comb begin
      cnt_s = cnt_r;
      if (!run) begin
         cnt_s = '0;
      end else if (cnt_r == LAST) begin
         cnt_s = '0;
      end else begin
         cnt_s = cnt_r + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_s;
      end
   end

   assign blank_end   = (cnt_r == BLAST);
   assign slot_end    = (cnt_r == LAST);
   assign slot_end_nx = (cnt_s == LAST);

endmodule

// File: rtl/seg_digit_scanner.sv
// Four-digit multiplexed display scanner with shadowed, frame-synchronous
// content update. Optional macro LEADING_ZERO_BLANK_EN darkens leading zeros.
module seg_digit_scanner
   import seg_pkg::*;
#(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] load_data,
   input  logic [3:0]  load_mode,
   input  logic [3:0]  load_dp,
   output logic        MODE,
   output logic [3:0]  DATA,
   output logic        dp_on,
   output logic [3:0]  an,
   output logic        frame_done
);

   state_t      state_r, state_s;
   logic [1:0]  idx_r, idx_s;
   disp_t       act_r, act_s, shd_r, shd_s, ld_s;
   logic        pend_r, pend_s;
   logic        commit_s, run_s;
   logic        blank_end_s, slot_end_s, slot_end_nx_s;
   logic [3:0]  an_s, data_s;
   logic        mode_s, dp_s, fd_s;

   seg_refresh_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .run        (run_s),
      .blank_end  (blank_end_s),
      .slot_end   (slot_end_s),
      .slot_end_nx(slot_end_nx_s)
   );

   // Scan FSM; the counter restarts from zero whenever IDLE is entered or left.
   always_comb begin
      state_s  = state_r;
      idx_s    = idx_r;
      commit_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            idx_s   = 2'd0;
            state_s = enable ? ST_BLANK : ST_IDLE;
         end
         ST_BLANK: begin
            if (!enable) begin
               state_s = ST_IDLE;
               idx_s   = 2'd0;
            end else if (blank_end_s) begin
               state_s = ST_SHOW;
            end else begin
               state_s = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (!enable) begin
               state_s = ST_IDLE;
               idx_s   = 2'd0;
            end else if (slot_end_s) begin
               state_s  = ST_BLANK;
               idx_s    = idx_r + 2'd1;
               commit_s = (idx_r == 2'd3);
            end else begin
               state_s = ST_SHOW;
            end
         end
         default: begin
            state_s = ST_IDLE;
            idx_s   = 2'd0;
         end
      endcase
      run_s = (state_r != ST_IDLE) && (state_s != ST_IDLE);
   end

   // Active content only changes in IDLE or at the frame boundary.
   always_comb begin
      ld_s   = '{data: load_data, mode: load_mode, dp: load_dp};
      act_s  = act_r;
      shd_s  = shd_r;
      pend_s = pend_r;
      if (load && (state_r == ST_IDLE)) begin
         act_s  = ld_s;
         pend_s = 1'b0;
      end else if (commit_s && load) begin
         act_s  = ld_s;
         pend_s = 1'b0;
      end else if (commit_s && pend_r) begin
         act_s  = shd_r;
         pend_s = 1'b0;
      end else if (load) begin
         shd_s  = ld_s;
         pend_s = 1'b1;
      end else begin
         pend_s = pend_r;
      end
   end

   // Outputs are computed from next-cycle values so they register with no lag.
   always_comb begin
      an_s   = 4'b1111;
      data_s = act_s.data[idx_s*NIBBLE_W +: NIBBLE_W];
      mode_s = act_s.mode[idx_s];
      dp_s   = act_s.dp[idx_s];
      fd_s   = (state_s == ST_SHOW) && (idx_s == 2'd3) && slot_end_nx_s;
      if (state_s == ST_SHOW) begin
         an_s = ~(4'b0001 << idx_s);
`ifdef LEADING_ZERO_BLANK_EN
         if (lead_zero(act_s.data, idx_s)) begin
            an_s = 4'b1111;
         end else begin
            an_s = ~(4'b0001 << idx_s);
         end
`endif
      end else begin
         an_s = 4'b1111;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         idx_r      <= 2'd0;
         act_r      <= '0;
         shd_r      <= '0;
         pend_r     <= 1'b0;
         an         <= 4'b1111;
         DATA       <= 4'h0;
         MODE       <= 1'b0;
         dp_on      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_r    <= state_s;
         idx_r      <= idx_s;
         act_r      <= act_s;
         shd_r      <= shd_s;
         pend_r     <= pend_s;
         an         <= an_s;
         DATA       <= data_s;
         MODE       <= mode_s;
         dp_on      <= dp_s;
         frame_done <= fd_s;
      end
   end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed self-checking bench for seg_digit_scanner (SLOT_CYCLES=8, BLANK_CYCLES=2).
// Expected digit enables honour LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg_digit_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        load;
   logic [15:0] load_data;
   logic [3:0]  load_mode;
   logic [3:0]  load_dp;
   logic        MODE;
   logic [3:0]  DATA;
   logic        dp_on;
   logic [3:0]  an;
   logic        frame_done;

   int ncmp = 0;
   int nerr = 0;

   seg_digit_scanner #(
      .SLOT_CYCLES (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .load      (load),
      .load_data (load_data),
      .load_mode (load_mode),
      .load_dp   (load_dp),
      .MODE      (MODE),
      .DATA      (DATA),
      .dp_on     (dp_on),
      .an        (an),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_an(input int slot, input logic [15:0] d);
      logic [3:0] r;
      logic [15:0] hi;
      r  = ~(4'b0001 << slot);
      hi = d >> (4 * slot);
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0 && hi == 16'h0000) r = 4'b1111;
`endif
      return r;
   endfunction

   // One frame (or its first ncyc cycles) starting from the first BLANK cycle.
   task automatic run_frame(input logic [15:0] d, input logic [3:0] m, input logic [3:0] dpv,
                            input int ncyc, input int ld_at, input logic [15:0] ld_d,
                            input logic [3:0] ld_m, input logic [3:0] ld_dp, input int drop_at);
      int slot, pos;
      logic [15:0] nib;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         slot = (c - 1) / 8;
         pos  = (c - 1) % 8;
         nib  = (d >> (4 * slot)) & 16'h000F;
         chk($sformatf("an@%0d", c), {12'h000, an}, (pos < 2) ? 16'h000F : {12'h000, exp_an(slot, d)});
         chk($sformatf("frame_done@%0d", c), {15'h0000, frame_done}, (c == 32) ? 16'h0001 : 16'h0000);
         if (pos >= 2) begin
            chk($sformatf("DATA@%0d", c), {12'h000, DATA}, nib);
            chk($sformatf("MODE@%0d", c), {15'h0000, MODE}, {15'h0000, m[slot]});
            chk($sformatf("dp_on@%0d", c), {15'h0000, dp_on}, {15'h0000, dpv[slot]});
         end
         load = (c == ld_at);
         if (c == ld_at) begin
            load_data = ld_d;
            load_mode = ld_m;
            load_dp   = ld_dp;
         end
         if (c == drop_at) enable = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; load = 1'b0;
      load_data = 16'h0000; load_mode = 4'h0; load_dp = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_an", {12'h000, an}, 16'h000F);
      chk("rst_DATA", {12'h000, DATA}, 16'h0000);
      chk("rst_MODE", {15'h0000, MODE}, 16'h0000);
      chk("rst_dp", {15'h0000, dp_on}, 16'h0000);
      chk("rst_fd", {15'h0000, frame_done}, 16'h0000);
      rst = 1'b0;

      // Direct load while idle, then start scanning.
      load = 1'b1; load_data = 16'h4321; load_mode = 4'b1010; load_dp = 4'b0100;
      @(negedge clk);
      load = 1'b0;
      chk("idle_an", {12'h000, an}, 16'h000F);
      enable = 1'b1;

      // Mid-frame load must not tear the frame on screen.
      run_frame(16'h4321, 4'b1010, 4'b0100, 32, 12, 16'hABCD, 4'b0101, 4'b0011, 0);
      // Load coincident with frame_done goes straight to the next frame.
      run_frame(16'hABCD, 4'b0101, 4'b0011, 32, 32, 16'h9E07, 4'b0011, 4'b1000, 0);
      run_frame(16'h9E07, 4'b0011, 4'b1000, 32, 0, 16'h0000, 4'h0, 4'h0, 0);
      // Drop enable while digit 1 is shown.
      run_frame(16'h9E07, 4'b0011, 4'b1000, 12, 0, 16'h0000, 4'h0, 4'h0, 12);
      @(negedge clk);
      chk("drop_an", {12'h000, an}, 16'h000F);
      chk("drop_fd", {15'h0000, frame_done}, 16'h0000);
      load = 1'b1; load_data = 16'h0050; load_mode = 4'b0001; load_dp = 4'b0010;
      @(negedge clk);
      load = 1'b0;
      chk("idle2_an", {12'h000, an}, 16'h000F);
      enable = 1'b1;
      run_frame(16'h0050, 4'b0001, 4'b0010, 32, 0, 16'h0000, 4'h0, 4'h0, 0);

      // Reset mid-frame beats a simultaneous load and enable.
      run_frame(16'h0050, 4'b0001, 4'b0010, 20, 0, 16'h0000, 4'h0, 4'h0, 0);
      rst = 1'b1; load = 1'b1; load_data = 16'hFFFF; load_mode = 4'hF; load_dp = 4'hF;
      @(negedge clk);
      chk("rst2_an", {12'h000, an}, 16'h000F);
      chk("rst2_DATA", {12'h000, DATA}, 16'h0000);
      chk("rst2_MODE", {15'h0000, MODE}, 16'h0000);
      chk("rst2_dp", {15'h0000, dp_on}, 16'h0000);
      chk("rst2_fd", {15'h0000, frame_done}, 16'h0000);
      rst = 1'b0; load = 1'b0;
      run_frame(16'h0000, 4'h0, 4'h0, 32, 0, 16'h0000, 4'h0, 4'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/seg_digit_scanner.md
SEG_DIGIT_SCANNER -- requirements
Module: seg_digit_scanner

Interface
REQ-001 Parameter SLOT_CYCLES, default 50000: clk cycles per digit slot; SHALL be greater than BLANK_CYCLES.
REQ-002 Parameter BLANK_CYCLES, default 4: all-digits-off cycles at the start of each slot (anti-ghosting); SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  scanning on when high.
REQ-006 load  input  1  one-cycle request to capture new display content.
REQ-007 load_data  input  16  four nibbles; digit k uses bits [4k+3:4k].
REQ-008 load_mode  input  4  per-digit MODE bit for the downstream decoder.
REQ-009 load_dp  input  4  per-digit decimal-point request.
REQ-010 MODE  output  1  registered mode bit of the digit being shown; drives the decoder MODE input.
REQ-011 DATA  output  4  registered nibble of the digit being shown; drives the decoder DATA input.
REQ-012 dp_on  output  1  registered decimal-point request for the digit being shown.
REQ-013 an  output  4  registered active-low digit enables; an[k] low lights digit k.
REQ-014 frame_done  output  1  one-cycle pulse when digit 3's slot ends.

Function
REQ-015 States SHALL be IDLE, BLANK and SHOW; slot counter and 2-bit digit index are internal.
REQ-016 IDLE: an SHALL be 4'b1111; on enable high, next state SHALL be BLANK with index 0 and counter 0.
REQ-017 BLANK: an SHALL be 4'b1111; counter increments; at counter == BLANK_CYCLES-1, next state SHALL be SHOW.
REQ-018 SHOW: an SHALL have only bit [index] low; DATA, MODE and dp_on SHALL come from the active register for that index.
REQ-019 SHOW at counter == SLOT_CYCLES-1: next state SHALL be BLANK, counter SHALL clear, and index SHALL increment, wrapping 3 -> 0.
REQ-020 On the 3 -> 0 wrap, frame_done SHALL pulse, and a pending shadow SHALL be copied to the active register and pending SHALL clear.
REQ-021 load outside IDLE SHALL write the shadow register and set pending; a later load before commit SHALL overwrite the shadow.
REQ-022 load in the same cycle as a commit SHALL write load_data, load_mode and load_dp directly to the active register and leave pending clear.
REQ-023 load while in IDLE SHALL write the active register directly.
REQ-024 enable low in any state SHALL move the block to IDLE on the next edge, with an = 4'b1111 from that edge; pending content SHALL be retained.
REQ-025 Active content SHALL never change mid-frame, so a displayed frame is never torn.
REQ-026 The counter SHALL be wide enough for SLOT_CYCLES-1 and SHALL never wrap outside the rules above.

Reset
REQ-027 rst SHALL force: state IDLE; counter 0; index 0; active, shadow and pending 0; an 4'b1111; DATA 0; MODE 0; dp_on 0; frame_done 0.
REQ-028 rst mid-frame SHALL take priority over load, enable and commit in the same cycle.

Configuration
REQ-029 Macro LEADING_ZERO_BLANK_EN defined: in SHOW, an SHALL stay 4'b1111 for digit k if k > 0 and active nibbles k..3 are all zero.
REQ-030 Digit 0 SHALL always light under LEADING_ZERO_BLANK_EN.
REQ-031 LEADING_ZERO_BLANK_EN undefined: all four digits SHALL light in turn, with no added logic.

Structure
REQ-032 Package seg_pkg SHALL hold the state enum, digit count (4) and nibble width (4).
REQ-033 Sub-module seg_refresh_timer (slot counter plus BLANK/SHOW boundary strobes) is natural; the digit register file and FSM stay in the top level.

Verification (SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-034 rst, then enable=1 -> an 1111 for 2 cycles; then 1110 for 6 cycles; 1111 for 2 cycles; 1101; and so on; frame_done pulses once every 32 cycles.
REQ-035 load in IDLE with load_data=16'h4321, then enable -> DATA sequence 1,2,3,4 aligned with an 1110,1101,1011,0111.
REQ-036 Mid-frame load with load_data=16'hABCD -> current frame still shows the old value; next frame shows D,C,B,A.
REQ-037 load coincident with the frame_done cycle -> the new value shows from digit 0 of the next frame; pending is 0 afterward.
REQ-038 enable dropped mid-SHOW -> an 1111 on the next edge; re-enable restarts at BLANK with digit 0.
REQ-039 With LEADING_ZERO_BLANK_EN, load_data=16'h0050 -> digits 2 and 3 stay dark, digits 0 and 1 light; load_data=0 -> only digit 0 lights.
